if_id_buffer: RTL and testbench
===============================

Name: if_id_buffer

Overview:
- Decoupling buffer between the instruction fetch stage and the decode stage.
- Captures {pc, instruction} pairs produced by fetch into a small FIFO.
- Presents them to decode with a valid/ready handshake.
- Supports a synchronous flush for branch/jump redirects and substitutes a NOP when empty.

Parameters:
- DEPTH, 2, number of entries; power of two, at least 2.
- NOP_INS, 32'h00000000, instruction word driven on out_ins when no entry is valid.
- PC_RESET, 32'h00400020, value driven on out_pc when no entry is valid.

Ports:
- clk  input  1  rising-edge clock.
- areset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  fetch presents a pair this cycle.
- in_pc  input  32  PC of the fetched instruction.
- in_ins  input  32  fetched instruction word.
- in_ready  output  1  buffer can accept; equals (count != DEPTH).
- out_valid  output  1  head entry valid; equals (count != 0).
- out_pc  output  32  head entry PC, or PC_RESET when empty.
- out_ins  output  32  head entry instruction, or NOP_INS when empty.
- out_misaligned  output  1  head entry in_pc[1:0] != 0; 0 when empty.
- out_ready  input  1  decode consumes the head this cycle.
- flush  input  1  discard all entries at the next edge.
- count  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (areset_n=0, asynchronous):
  - count=0, read/write pointers=0, out_valid=0, in_ready=1.
  - out_pc=PC_RESET, out_ins=NOP_INS, out_misaligned=0.
  - Entry storage contents don't care.
- Deassertion is sampled at the next rising edge. No push or pop occurs on any edge while areset_n=0.
- Push: at a rising edge where in_valid && in_ready && !flush:
  - write {in_pc, in_ins, in_pc[1:0]!=0} at wr_ptr;
  - wr_ptr increments modulo DEPTH.
- Pop: at a rising edge where out_valid && out_ready && !flush, rd_ptr increments modulo DEPTH.
- count update: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Latency:
  - A pair pushed at edge N is visible on out_* after edge N when the buffer was empty; otherwise after all older entries have popped.
  - No combinational path from in_* to out_*.
- in_ready depends only on count. It never depends on out_ready, so there is no same-cycle bypass when full.
- Outputs are driven from the head entry muxed by rd_ptr. When count=0 the empty defaults above apply. No X may propagate.
- Flush:
  - Takes priority over push and pop at the same edge.
  - Next state: count=0, rd_ptr=wr_ptr=0.
  - A concurrent in_valid pair is dropped, and out_ready is ignored that edge.
- Full (count=DEPTH):
  - in_ready=0; in_valid is ignored.
  - A pop that edge frees a slot, visible as in_ready=1 the following cycle.
- Empty (count=0):
  - out_valid=0; out_ready is ignored and the pointers hold.
  - A push is allowed.
- Pointer wrap: wr_ptr and rd_ptr wrap from DEPTH-1 to 0 with no loss of ordering.
- Handshake rule for the upstream: while in_valid=1 and in_ready=0, in_pc and in_ins must stay stable. The buffer does not check this.
- Reset mid-operation clears all occupancy immediately, regardless of flush, in_valid or out_ready.

Test Plan:
- Reset then idle, areset_n low 3 cycles, then in_valid=0, out_ready=0 -> out_valid=0, in_ready=1, count=0, out_pc=32'h00400020, out_ins=32'h00000000.
- Single pass, one cycle in_valid=1, in_pc=32'h00400020, in_ins=32'h8C080004, out_ready=1 -> next cycle out_valid=1 with that pc/ins. After the following edge out_valid=0 and count=0.
- Fill and back-pressure, out_ready=0, push pc 0x00400020 then 0x00400024 -> count=2, in_ready=0. A third push of 0x00400028 is ignored. Then out_ready=1 -> outputs 0x00400020, then 0x00400024, in order.
- Simultaneous push/pop at count=1 over 6 cycles with sequential PCs -> count stays 1, pointers wrap, and out_pc sequence equals the in_pc sequence delayed by one.
- Flush with push, count=2 plus in_valid=1, pc=0x00400030, flush=1 -> next cycle count=0, out_valid=0, and 0x00400030 never appears at the output.
- Misaligned input and mid-operation reset: push pc=0x00400022 -> out_misaligned=1. Then at count=2 pulse areset_n low asynchronously mid-cycle -> count=0 and out_valid=0 immediately, before the next edge.

Source files
------------

// File: rtl/if_id_buffer.sv
// IF/ID decoupling buffer: a small FIFO of {pc, instruction, misaligned} entries
// between fetch and decode, with synchronous flush and NOP/PC_RESET defaults when empty.
module if_id_buffer #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP_INS  = 32'h00000000,
  parameter logic [31:0] PC_RESET = 32'h00400020
) (
  input  logic                       clk,
  input  logic                       areset_n,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_ins,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_ins,
  output logic                       out_misaligned,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];
  logic          mis_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Handshake: a transfer happens on a rising edge when valid && ready are both
  // high on that side; flush cancels both transfers. in_ready depends only on
  // count, so a full buffer never accepts in the same cycle it pops.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; empty-state outputs are muxed to constants below.
  always_ff @(posedge clk) begin
    if (push && areset_n) begin
      pc_mem[wr_ptr]  <= in_pc;
      ins_mem[wr_ptr] <= in_ins;
      mis_mem[wr_ptr] <= (in_pc[1:0] != 2'b00);
    end
  end

  always_comb begin
    out_pc         = PC_RESET;
    out_ins        = NOP_INS;
    out_misaligned = 1'b0;
    if (out_valid) begin
      out_pc         = pc_mem[rd_ptr];
      out_ins        = ins_mem[rd_ptr];
      out_misaligned = mis_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: reset, pass-through, back-pressure, wrap,
// flush priority, misaligned flag and asynchronous mid-cycle reset.
module tb_if_id_buffer;

  localparam logic [31:0] PC_RESET = 32'h00400020;
  localparam logic [31:0] NOP_INS  = 32'h00000000;

  logic        clk = 1'b0;
  logic        areset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_ins = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_ins;
  logic        out_misaligned;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  if_id_buffer #(.DEPTH(2), .NOP_INS(NOP_INS), .PC_RESET(PC_RESET)) dut (
    .clk(clk), .areset_n(areset_n),
    .in_valid(in_valid), .in_pc(in_pc), .in_ins(in_ins), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_ins(out_ins),
    .out_misaligned(out_misaligned), .out_ready(out_ready),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".count"}, 32'(count), 32'd0);
    check({tag, ".out_pc"}, out_pc, PC_RESET);
    check({tag, ".out_ins"}, out_ins, NOP_INS);
    check({tag, ".out_mis"}, 32'(out_misaligned), 32'd0);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    in_valid = 1'b1;
    in_pc    = pc;
    in_ins   = ins;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] prev_pc;
    logic [31:0] cur_pc;

    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    areset_n = 1'b1;
    tick();
    check_empty("reset");

    // Single pass with out_ready held high
    out_ready = 1'b1;
    push(32'h00400020, 32'h8C080004);
    check("single.valid", 32'(out_valid), 32'd1);
    check("single.pc", out_pc, 32'h00400020);
    check("single.ins", out_ins, 32'h8C080004);
    check("single.count", 32'(count), 32'd1);
    tick();
    check("single.drain_valid", 32'(out_valid), 32'd0);
    check("single.drain_count", 32'(count), 32'd0);

    // Fill and back-pressure
    out_ready = 1'b0;
    push(32'h00400020, 32'h00000111);
    check("fill.count1", 32'(count), 32'd1);
    push(32'h00400024, 32'h00000222);
    check("fill.count2", 32'(count), 32'd2);
    check("fill.in_ready", 32'(in_ready), 32'd0);
    push(32'h00400028, 32'h00000333);
    check("fill.ignored_count", 32'(count), 32'd2);
    check("fill.head_pc", out_pc, 32'h00400020);
    check("fill.head_ins", out_ins, 32'h00000111);
    out_ready = 1'b1;
    tick();
    check("fill.pop1_pc", out_pc, 32'h00400024);
    check("fill.pop1_ins", out_ins, 32'h00000222);
    check("fill.pop1_count", 32'(count), 32'd1);
    check("fill.pop1_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("fill.pop2_valid", 32'(out_valid), 32'd0);

    // Simultaneous push/pop at count=1, pointers wrap several times
    out_ready = 1'b0;
    prev_pc = 32'h00400100;
    push(prev_pc, 32'hA0000000);
    out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cur_pc   = 32'h00400100 + 32'(4 * i);
      in_valid = 1'b1;
      in_pc    = cur_pc;
      in_ins   = 32'hA0000000 + 32'(i);
      check("stream.pre_pc", out_pc, prev_pc);
      tick();
      check("stream.count", 32'(count), 32'd1);
      check("stream.post_pc", out_pc, cur_pc);
      check("stream.post_ins", out_ins, 32'hA0000000 + 32'(i));
      prev_pc = cur_pc;
    end
    in_valid = 1'b0;
    tick();
    check("stream.drain_count", 32'(count), 32'd0);

    // Flush beats a concurrent push and pop
    out_ready = 1'b0;
    push(32'h00400040, 32'h00000440);
    push(32'h00400044, 32'h00000444);
    check("flush.pre_count", 32'(count), 32'd2);
    in_valid  = 1'b1;
    in_pc     = 32'h00400030;
    in_ins    = 32'h00000330;
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_empty("flush");
    tick();
    check("flush.stays_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    push(32'h00400050, 32'h00000550);
    check("flush.next_pc", out_pc, 32'h00400050);
    check("flush.next_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("flush.next_drain", 32'(count), 32'd0);

    // Misaligned head, then asynchronous reset mid-cycle
    push(32'h00400022, 32'h00000022);
    check("mis.flag", 32'(out_misaligned), 32'd1);
    check("mis.pc", out_pc, 32'h00400022);
    push(32'h00400024, 32'h00000024);
    check("mis.count2", 32'(count), 32'd2);
    check("mis.head_flag", 32'(out_misaligned), 32'd1);
    #2;
    areset_n = 1'b0;
    #1;
    check_empty("async_reset");
    in_valid  = 1'b1;
    in_pc     = 32'h00400060;
    out_ready = 1'b1;
    tick();
    check("reset_hold.count", 32'(count), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    areset_n = 1'b1;
    tick();
    check_empty("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
